// File: rtl/hms_time_counter_if.sv
// Bundles the time-of-day counter's set/tick inputs and BCD display outputs.
// The master side drives tick/run/set levels; the counter is the slave.
interface hms_time_counter_if;
    logic       tick_1hz;
    logic       run;
    logic       inc_min;
    logic       inc_hour;
    logic [3:0] sec_ones;
    logic [2:0] sec_tens;
    logic [3:0] min_ones;
    logic [2:0] min_tens;
    logic [3:0] hr_ones;
    logic [1:0] hr_tens;
    logic       pm;
    logic       sec_pulse;

    modport master (
        output tick_1hz, run, inc_min, inc_hour,
        input  sec_ones, sec_tens, min_ones, min_tens, hr_ones, hr_tens, pm, sec_pulse
    );

    modport slave (
        input  tick_1hz, run, inc_min, inc_hour,
        output sec_ones, sec_tens, min_ones, min_tens, hr_ones, hr_tens, pm, sec_pulse
    );
endinterface

// File: rtl/hms_time_counter.sv
// BCD time-of-day counter driven by the 1 Hz divider output, with +1 minute /
// +1 hour set inputs, 12 h or 24 h display and a one-cycle seconds strobe.
module hms_time_counter #(
    parameter int HOURS_24 = 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    hms_time_counter_if.slave bus
);

    localparam logic       MODE24      = (HOURS_24 != 0);
    localparam logic [1:0] HR_TENS_RST = MODE24 ? 2'd0 : 2'd1;
    localparam logic [3:0] HR_ONES_RST = MODE24 ? 4'd0 : 4'd2;

    // Two-digit 00..59 increment; result is {wrap, tens, ones}.
    function automatic logic [7:0] inc_sexa(input logic [3:0] ones, input logic [2:0] tens);
        logic [7:0] r;
        if (ones != 4'd9)
            r = {1'b0, tens, ones + 4'd1};
        else if (tens != 3'd5)
            r = {1'b0, tens + 3'd1, 4'd0};
        else
            r = {1'b1, 3'd0, 4'd0};
        return r;
    endfunction

    // Hour increment with mode wrap; result is {pm, tens, ones}.
    function automatic logic [6:0] inc_hr(input logic [1:0] tens, input logic [3:0] ones,
                                          input logic pm);
        logic [6:0] r;
        if (MODE24) begin
            if (tens == 2'd2 && ones == 4'd3)
                r = {1'b0, 2'd0, 4'd0};
            else if (ones == 4'd9)
                r = {1'b0, tens + 2'd1, 4'd0};
            else
                r = {1'b0, tens, ones + 4'd1};
        end else begin
            if (tens == 2'd1 && ones == 4'd2)
                r = {pm, 2'd0, 4'd1};
            else if (tens == 2'd1 && ones == 4'd1)
                r = {~pm, 2'd1, 4'd2};
            else if (ones == 4'd9)
                r = {pm, 2'd1, 4'd0};
            else
                r = {pm, tens, ones + 4'd1};
        end
        return r;
    endfunction

    logic       tick_q, inc_min_q, inc_hour_q;
    logic [3:0] sec_ones_q, sec_ones_d;
    logic [2:0] sec_tens_q, sec_tens_d;
    logic [3:0] min_ones_q, min_ones_d;
    logic [2:0] min_tens_q, min_tens_d;
    logic [3:0] hr_ones_q,  hr_ones_d;
    logic [1:0] hr_tens_q,  hr_tens_d;
    logic       pm_q,       pm_d;
    logic       sec_pulse_q, sec_pulse_d;

    logic       tick_rise, min_rise, hour_rise, do_sec;
    logic [7:0] sec_nx, min_nx;
    logic [6:0] hr_nx;

    assign tick_rise = bus.tick_1hz & ~tick_q;
    assign min_rise  = bus.inc_min  & ~inc_min_q;
    assign hour_rise = bus.inc_hour & ~inc_hour_q;
    // Any set edge wins over a simultaneous tick; the tick is simply lost.
    assign do_sec    = tick_rise & bus.run & ~min_rise & ~hour_rise;

    assign sec_nx = inc_sexa(sec_ones_q, sec_tens_q);
    assign min_nx = inc_sexa(min_ones_q, min_tens_q);
    assign hr_nx  = inc_hr(hr_tens_q, hr_ones_q, pm_q);

    always_comb begin
        sec_ones_d  = sec_ones_q;
        sec_tens_d  = sec_tens_q;
        min_ones_d  = min_ones_q;
        min_tens_d  = min_tens_q;
        hr_ones_d   = hr_ones_q;
        hr_tens_d   = hr_tens_q;
        pm_d        = pm_q;
        sec_pulse_d = do_sec;

        if (do_sec) begin
            sec_tens_d = sec_nx[6:4];
            sec_ones_d = sec_nx[3:0];
            if (sec_nx[7]) begin
                min_tens_d = min_nx[6:4];
                min_ones_d = min_nx[3:0];
                if (min_nx[7]) begin
                    pm_d      = hr_nx[6];
                    hr_tens_d = hr_nx[5:4];
                    hr_ones_d = hr_nx[3:0];
                end
            end
        end

        if (min_rise) begin
            min_tens_d = min_nx[6:4];
            min_ones_d = min_nx[3:0];
            sec_tens_d = 3'd0;
            sec_ones_d = 4'd0;
        end

        if (hour_rise) begin
            pm_d      = hr_nx[6];
            hr_tens_d = hr_nx[5:4];
            hr_ones_d = hr_nx[3:0];
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            tick_q      <= 1'b1;
            inc_min_q   <= 1'b1;
            inc_hour_q  <= 1'b1;
            sec_ones_q  <= 4'd0;
            sec_tens_q  <= 3'd0;
            min_ones_q  <= 4'd0;
            min_tens_q  <= 3'd0;
            hr_ones_q   <= HR_ONES_RST;
            hr_tens_q   <= HR_TENS_RST;
            pm_q        <= 1'b0;
            sec_pulse_q <= 1'b0;
        end else begin
            tick_q      <= bus.tick_1hz;
            inc_min_q   <= bus.inc_min;
            inc_hour_q  <= bus.inc_hour;
            sec_ones_q  <= sec_ones_d;
            sec_tens_q  <= sec_tens_d;
            min_ones_q  <= min_ones_d;
            min_tens_q  <= min_tens_d;
            hr_ones_q   <= hr_ones_d;
            hr_tens_q   <= hr_tens_d;
            pm_q        <= pm_d;
            sec_pulse_q <= sec_pulse_d;
        end
    end

    assign bus.sec_ones  = sec_ones_q;
    assign bus.sec_tens  = sec_tens_q;
    assign bus.min_ones  = min_ones_q;
    assign bus.min_tens  = min_tens_q;
    assign bus.hr_ones   = hr_ones_q;
    assign bus.hr_tens   = hr_tens_q;
    assign bus.pm        = pm_q;
    assign bus.sec_pulse = sec_pulse_q;

endmodule

// File: tb/tb_hms_time_counter.sv
// Bench for hms_time_counter: a 24 h and a 12 h instance share one stimulus
// stream; a seconds-of-day model predicts both displays every cycle.
module tb_hms_time_counter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tick, run, im, ih;
    int   checks = 0;
    int   errors = 0;
    int   pulses = 0;

    always #5 clk = ~clk;

    hms_time_counter_if b24();
    hms_time_counter_if b12();

    assign b24.tick_1hz = tick;
    assign b24.run      = run;
    assign b24.inc_min  = im;
    assign b24.inc_hour = ih;
    assign b12.tick_1hz = tick;
    assign b12.run      = run;
    assign b12.inc_min  = im;
    assign b12.inc_hour = ih;

    hms_time_counter #(.HOURS_24(1)) dut24 (.clk_i(clk), .reset_i(reset), .bus(b24));
    hms_time_counter #(.HOURS_24(0)) dut12 (.clk_i(clk), .reset_i(reset), .bus(b12));

    logic [21:0] got24, got12;
    assign got24 = {b24.sec_ones, b24.sec_tens, b24.min_ones, b24.min_tens,
                    b24.hr_ones, b24.hr_tens, b24.pm, b24.sec_pulse};
    assign got12 = {b12.sec_ones, b12.sec_tens, b12.min_ones, b12.min_tens,
                    b12.hr_ones, b12.hr_tens, b12.pm, b12.sec_pulse};

    // Displayed digits as written on a clock face.
    function automatic logic [21:0] lit_vec(int hh, int mm, int ss, bit pm, bit pl);
        return {4'(ss % 10), 3'(ss / 10), 4'(mm % 10), 3'(mm / 10),
                4'(hh % 10), 2'(hh / 10), pm, pl};
    endfunction

    function automatic logic [21:0] exp_vec(int t, bit pl, bit h24);
        int h;
        bit pm;
        h  = t / 3600;
        pm = 1'b0;
        if (!h24) begin
            pm = (h >= 12);
            h  = h % 12;
            if (h == 0) h = 12;
        end
        return lit_vec(h, (t / 60) % 60, t % 60, pm, pl);
    endfunction

    function automatic int model_next(int t, bit tr, bit mr, bit hr, bit rn);
        int h, m, s;
        h = t / 3600;
        m = (t / 60) % 60;
        s = t % 60;
        if (mr || hr) begin
            if (mr) begin
                m = (m + 1) % 60;
                s = 0;
            end
            if (hr) h = (h + 1) % 24;
            return h * 3600 + m * 60 + s;
        end
        if (tr && rn) return (t + 1) % 86400;
        return t;
    endfunction

    // Reference model: time as seconds since midnight.
    int   tsec = 0;
    logic mp_tick = 1'b1, mp_min = 1'b1, mp_hour = 1'b1, m_pulse = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            tsec    <= 0;
            mp_tick <= 1'b1;
            mp_min  <= 1'b1;
            mp_hour <= 1'b1;
            m_pulse <= 1'b0;
        end else begin
            tsec    <= model_next(tsec, tick & ~mp_tick, im & ~mp_min, ih & ~mp_hour, run);
            m_pulse <= (tick & ~mp_tick) & run & ~(im & ~mp_min) & ~(ih & ~mp_hour);
            mp_tick <= tick;
            mp_min  <= im;
            mp_hour <= ih;
        end
    end

    task automatic chk(input string name, input logic [21:0] got, input logic [21:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            if (b24.sec_pulse === 1'b1) pulses++;
            chk("model24", got24, exp_vec(tsec, m_pulse, 1'b1));
            chk("model12", got12, exp_vec(tsec, m_pulse, 1'b0));
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        tick = 1'b0;
        step(1);
        tick = 1'b1;
        step(1);
    endtask

    task automatic pulse_min();
        im = 1'b1;
        step(1);
        im = 1'b0;
        step(1);
    endtask

    task automatic pulse_hour();
        ih = 1'b1;
        step(1);
        ih = 1'b0;
        step(1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step(2);
        reset = 1'b1;
        step(1);
    endtask

    task automatic preset(input int h, input int m, input int s);
        do_reset();
        repeat (h) pulse_hour();
        repeat (m) pulse_min();
        repeat (s) do_tick();
    endtask

    initial begin
        tick = 1'b1;
        run  = 1'b1;
        im   = 1'b1;
        ih   = 1'b1;
        #1 reset = 1'b0;
        fork
            compare_loop();
        join_none

        // Release with all inputs already high: no edges, no count.
        step(3);
        chk("reset24", got24, lit_vec(0, 0, 0, 1'b0, 1'b0));
        chk("reset12", got12, lit_vec(12, 0, 0, 1'b0, 1'b0));
        reset = 1'b1;
        step(5);
        chk("hold_after_release", got24, lit_vec(0, 0, 0, 1'b0, 1'b0));
        im = 1'b0;
        ih = 1'b0;
        step(1);

        // 61 seconds.
        pulses = 0;
        repeat (61) do_tick();
        step(2);
        chk("61s_24", got24, lit_vec(0, 1, 1, 1'b0, 1'b0));
        chk("61s_12", got12, lit_vec(12, 1, 1, 1'b0, 1'b0));
        chk("pulse_count", 22'(pulses), 22'd61);

        // Full-day rollover; also pin the 12 h noon and 13:00 transitions.
        do_reset();
        for (int i = 1; i <= 23; i++) begin
            pulse_hour();
            if (i == 11) chk("h11_am", got12, lit_vec(11, 0, 0, 1'b0, 1'b0));
            if (i == 12) chk("h12_pm", got12, lit_vec(12, 0, 0, 1'b1, 1'b0));
            if (i == 13) chk("h01_pm", got12, lit_vec(1, 0, 0, 1'b1, 1'b0));
        end
        repeat (59) pulse_min();
        repeat (59) do_tick();
        chk("pre_roll24", got24, lit_vec(23, 59, 59, 1'b0, 1'b1));
        chk("pre_roll12", got12, lit_vec(11, 59, 59, 1'b1, 1'b1));
        do_tick();
        chk("roll24", got24, lit_vec(0, 0, 0, 1'b0, 1'b1));
        chk("roll12", got12, lit_vec(12, 0, 0, 1'b0, 1'b1));

        // inc_min clears seconds; 59 -> 00 without touching hours.
        preset(0, 0, 37);
        pulse_min();
        chk("inc_min", got24, lit_vec(0, 1, 0, 1'b0, 1'b0));
        repeat (58) pulse_min();
        repeat (5) do_tick();
        chk("min59", got24, lit_vec(0, 59, 5, 1'b0, 1'b1));
        pulse_min();
        chk("min_wrap", got24, lit_vec(0, 0, 0, 1'b0, 1'b0));

        // Tick coincident with inc_hour is dropped.
        preset(5, 10, 20);
        tick = 1'b0;
        step(1);
        tick = 1'b1;
        ih   = 1'b1;
        step(1);
        chk("tick_hour_same", got24, lit_vec(6, 10, 20, 1'b0, 1'b0));
        ih = 1'b0;
        step(1);
        chk("no_pulse_after", got24, lit_vec(6, 10, 20, 1'b0, 1'b0));
        im = 1'b1;
        ih = 1'b1;
        step(1);
        chk("both_sets", got24, lit_vec(7, 11, 0, 1'b0, 1'b0));
        im = 1'b0;
        ih = 1'b0;
        step(1);

        // Hold with run=0, then resume without catch-up.
        run = 1'b0;
        repeat (5) do_tick();
        step(1);
        chk("run0_hold", got24, lit_vec(7, 11, 0, 1'b0, 1'b0));
        run = 1'b1;
        step(3);
        chk("run1_no_catchup", got24, lit_vec(7, 11, 0, 1'b0, 1'b0));
        do_tick();
        chk("run1_tick", got24, lit_vec(7, 11, 1, 1'b0, 1'b1));

        // Reset right after the 09:59:59 -> 10:00:00 carry edge.
        preset(9, 59, 59);
        chk("pre_carry", got12, lit_vec(9, 59, 59, 1'b0, 1'b1));
        tick = 1'b0;
        step(1);
        tick = 1'b1;
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("reset_mid24", got24, lit_vec(0, 0, 0, 1'b0, 1'b0));
        chk("reset_mid12", got12, lit_vec(12, 0, 0, 1'b0, 1'b0));
        step(1);
        reset = 1'b1;
        step(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
